// File: rtl/tt_um_hoene_fade_controller.sv
// Ramps the three PWM duty registers toward commanded targets, one bounded step per PWM period.
// Define TT_HOENE_FADE_EN for fading; otherwise the block is a period-aligned double buffer.
module tt_um_hoene_fade_controller #(
  parameter int WIDTH         = 10,
  parameter int PRESCALE_BITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] target_red,
  input  logic [WIDTH-1:0] target_green,
  input  logic [WIDTH-1:0] target_blue,
  input  logic             target_valid,
  input  logic [3:0]       fade_step,
  output logic [WIDTH-1:0] data_red,
  output logic [WIDTH-1:0] data_green,
  output logic [WIDTH-1:0] data_blue,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, FADING} state_t;

  state_t                   state_q, state_n;
  logic [PRESCALE_BITS-1:0] prescaler;
  logic                     tick;
  logic [WIDTH-1:0]         tgt_red_q, tgt_green_q, tgt_blue_q;
  logic [WIDTH-1:0]         tgt_red_n, tgt_green_n, tgt_blue_n;
  logic [WIDTH-1:0]         data_red_n, data_green_n, data_blue_n;
  logic                     done_n;

  assign tick = &prescaler;
  assign busy = (state_q == FADING);

`ifdef TT_HOENE_FADE_EN
  logic [3:0] step_q, step_n;

  // Differences are taken at WIDTH+1 bits; the clamp keeps the result inside the target range.
  function automatic logic [WIDTH-1:0] approach(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] tgt,
                                                input logic [3:0]       step);
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   stp;
    logic [WIDTH-1:0] stp_w;
    diff     = '0;
    stp      = {{(WIDTH-3){1'b0}}, step};
    stp_w    = {{(WIDTH-4){1'b0}}, step};
    approach = cur;
    if (cur < tgt) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      approach = (diff <= stp) ? tgt : cur + stp_w;
    end else if (cur > tgt) begin
      diff = {1'b0, cur} - {1'b0, tgt};
      approach = (diff <= stp) ? tgt : cur - stp_w;
    end
  endfunction

  always_comb begin
    state_n      = state_q;
    tgt_red_n    = tgt_red_q;
    tgt_green_n  = tgt_green_q;
    tgt_blue_n   = tgt_blue_q;
    step_n       = step_q;
    data_red_n   = data_red;
    data_green_n = data_green;
    data_blue_n  = data_blue;
    done_n       = 1'b0;
    if (target_valid) begin
      tgt_red_n   = target_red;
      tgt_green_n = target_green;
      tgt_blue_n  = target_blue;
      step_n      = fade_step;
      if (fade_step == 4'd0 ||
          (target_red == data_red && target_green == data_green && target_blue == data_blue)) begin
        data_red_n   = target_red;
        data_green_n = target_green;
        data_blue_n  = target_blue;
        done_n       = 1'b1;
        state_n      = IDLE;
      end else begin
        state_n = FADING;
      end
    end else if (state_q == FADING && tick) begin
      data_red_n   = approach(data_red,   tgt_red_q,   step_q);
      data_green_n = approach(data_green, tgt_green_q, step_q);
      data_blue_n  = approach(data_blue,  tgt_blue_q,  step_q);
      if (data_red_n == tgt_red_q && data_green_n == tgt_green_q && data_blue_n == tgt_blue_q) begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= '0;
    else        step_q <= step_n;
  end
`else
  logic unused_step;
  assign unused_step = ^fade_step;

  always_comb begin
    state_n      = state_q;
    tgt_red_n    = tgt_red_q;
    tgt_green_n  = tgt_green_q;
    tgt_blue_n   = tgt_blue_q;
    data_red_n   = data_red;
    data_green_n = data_green;
    data_blue_n  = data_blue;
    done_n       = 1'b0;
    if (target_valid) begin
      tgt_red_n   = target_red;
      tgt_green_n = target_green;
      tgt_blue_n  = target_blue;
      state_n     = FADING;
    end else if (state_q == FADING && tick) begin
      data_red_n   = tgt_red_q;
      data_green_n = tgt_green_q;
      data_blue_n  = tgt_blue_q;
      done_n       = 1'b1;
      state_n      = IDLE;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prescaler   <= '0;
      tgt_red_q   <= '0;
      tgt_green_q <= '0;
      tgt_blue_q  <= '0;
      data_red    <= '0;
      data_green  <= '0;
      data_blue   <= '0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_n;
      prescaler   <= prescaler + 1'b1;
      tgt_red_q   <= tgt_red_n;
      tgt_green_q <= tgt_green_n;
      tgt_blue_q  <= tgt_blue_n;
      data_red    <= data_red_n;
      data_green  <= data_green_n;
      data_blue   <= data_blue_n;
      done        <= done_n;
    end
  end

endmodule
